// File: rtl/rs_pkg.sv
// rs_pkg: FSM state encoding and a constant-width helper shared by the
// receive_serializer block.
package rs_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  function automatic int rs_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rs_word_select.sv
// rs_word_select: NUM_CH-to-1 mux picking one data/address pair from the
// packed shadow buses.
module rs_word_select #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 19,
  parameter int ADDR_W = 6,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  input  logic [SEL_W-1:0]         i_sel,
  output logic [DATA_W-1:0]        o_data,
  output logic [ADDR_W-1:0]        o_addr
);
  always_comb begin
    o_data = '0;
    o_addr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_data[k*DATA_W +: DATA_W];
        o_addr = i_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end
endmodule

// File: rtl/receive_serializer.sv
// receive_serializer: captures NUM_CH data/address pairs on start and
// streams them out one word per accepted handshake.
module receive_serializer
  import rs_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 19,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH*ADDR_W-1:0] addr_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        data_out,
  output logic [ADDR_W-1:0]        addr_out,
  output logic                     busy,
  output logic                     done
);
  localparam int CW = rs_clog2(NUM_CH);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  state_t                   r_state;
  state_t                   w_next;
  logic [CW-1:0]            r_ch;
  logic [NUM_CH*DATA_W-1:0] r_data;
  logic [NUM_CH*ADDR_W-1:0] r_addr;
  logic                     r_done;
  logic                     w_cap;
  logic                     w_xfer;
  logic                     w_last;
  logic [DATA_W-1:0]        w_data;
  logic [ADDR_W-1:0]        w_addr;
  always_comb begin
    w_cap  = (r_state == IDLE) && start;
    w_xfer = (r_state == SEND) && out_ready;
    w_last = r_ch == LAST;
    w_next = w_cap ? SEND : (w_xfer && w_last) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Shadow buses are loaded only on the IDLE capture edge, so input changes
  // during SEND never reach the output stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch   <= '0;
      r_data <= '0;
      r_addr <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;
      if (w_cap) begin
        r_data <= data_in;
        r_addr <= addr_in;
        r_ch   <= '0;
      end else if (w_xfer) begin
        r_ch <= w_last ? '0 : r_ch + 1'b1;
      end
    end
  end
  rs_word_select #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SEL_W (CW)
  ) u_sel (
    .i_data(r_data),
    .i_addr(r_addr),
    .i_sel (r_ch),
    .o_data(w_data),
    .o_addr(w_addr)
  );
  assign out_valid = r_state == SEND;
  assign busy      = out_valid;
  assign data_out  = out_valid ? w_data : '0;
  assign addr_out  = out_valid ? w_addr : '0;
  assign done      = r_done;
endmodule

// File: tb/tb_receive_serializer.sv
// tb_receive_serializer: queue-based reference model plus directed bursts for
// the default configuration and a 2-channel 8-bit instance.
module tb_receive_serializer;
  localparam int NC = 8;
  localparam int DW = 19;
  localparam int AW = 6;
  logic clk;
  logic rst_n;
  logic start, out_ready;
  logic [NC*DW-1:0] data_in;
  logic [NC*AW-1:0] addr_in;
  logic ov, bsy, dn;
  logic [DW-1:0] dout;
  logic [AW-1:0] aout;
  logic start2;
  logic [2*8-1:0] data2;
  logic [2*AW-1:0] addr2;
  logic ov2, bsy2, dn2;
  logic [7:0] dout2;
  logic [AW-1:0] aout2;
  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;
  logic [DW-1:0] qd[$];
  logic [AW-1:0] qa[$];
  logic m_done = 1'b0;

  receive_serializer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .addr_in(addr_in),
    .out_ready(out_ready), .out_valid(ov), .data_out(dout), .addr_out(aout),
    .busy(bsy), .done(dn)
  );
  receive_serializer #(.NUM_CH(2), .DATA_W(8), .ADDR_W(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .data_in(data2), .addr_in(addr2),
    .out_ready(1'b1), .out_valid(ov2), .data_out(dout2), .addr_out(aout2),
    .busy(bsy2), .done(dn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ed(input int base, input int step, input int k);
    return 32'(base + k * step) & ((32'd1 << DW) - 32'd1);
  endfunction

  function automatic logic [31:0] ea(input int base, input int k);
    return 32'(base + k) & ((32'd1 << AW) - 32'd1);
  endfunction

  task automatic set_bus(input int base, input int step, input int abase);
    for (int k = 0; k < NC; k++) begin
      data_in[k*DW +: DW] = DW'(base + k * step);
      addr_in[k*AW +: AW] = AW'(abase + k);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!dn && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!dn) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
  endtask

  // Reference: a capture enqueues every channel; the head of the queue is the
  // word on the bus; each accepted word is popped; emptying the queue is done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qd.delete();
      qa.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (qd.size() != 0) begin
        if (out_ready) begin
          void'(qd.pop_front());
          void'(qa.pop_front());
          m_done = qd.size() == 0;
        end
      end else if (start) begin
        for (int k = 0; k < NC; k++) begin
          qd.push_back(data_in[k*DW +: DW]);
          qa.push_back(addr_in[k*AW +: AW]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", 32'(ov), 32'(qd.size() != 0));
      check("m_busy", 32'(bsy), 32'(qd.size() != 0));
      check("m_data", 32'(dout), qd.size() != 0 ? 32'(qd[0]) : 32'd0);
      check("m_addr", 32'(aout), qa.size() != 0 ? 32'(qa[0]) : 32'd0);
      check("m_done", 32'(dn), 32'(m_done));
    end
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b1;
    data_in = '0; addr_in = '0;
    start2 = 1'b0; data2 = '0; addr2 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(ov), 32'd0);
    check("rst_data", 32'(dout), 32'd0);
    check("rst_addr", 32'(aout), 32'd0);
    check("rst_busy", 32'(bsy), 32'd0);
    check("rst_done", 32'(dn), 32'd0);
    check("rst_valid2", 32'(ov2), 32'd0);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;
    // Basic burst: channel k at cycle k+1, done at cycle 9.
    set_bus(-3500, 1000, 8);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      check($sformatf("b1_valid%0d", k), 32'(ov), 32'd1);
      check($sformatf("b1_data%0d", k), 32'(dout), ed(-3500, 1000, k));
      check($sformatf("b1_addr%0d", k), 32'(aout), ea(8, k));
    end
    @(negedge clk);
    check("b1_done", 32'(dn), 32'd1);
    check("b1_idle", 32'(ov), 32'd0);
    @(negedge clk);
    check("b1_done_pulse", 32'(dn), 32'd0);
    // Stall on channel 3 while inputs and start churn during SEND.
    set_bus(-5, -37, 40);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 set_bus(12345, 7, 1);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2_hold_data%0d", i), 32'(dout), ed(-5, -37, 3));
      check($sformatf("b2_hold_addr%0d", i), 32'(aout), ea(40, 3));
      @(posedge clk); #1;
      if (i == 2) out_ready = 1'b1;
    end
    @(negedge clk);
    check("b2_next", 32'(dout), ed(-5, -37, 4));
    wait_done(20);
    // Back-to-back bursts: start in the done cycle.
    set_bus(-262144, 65536, 20);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(20);
    check("b3_gap", 32'(ov), 32'd0);
    set_bus(262143, -1000, 50);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("b4_valid", 32'(ov), 32'd1);
    check("b4_data0", 32'(dout), ed(262143, -1000, 0));
    check("b4_addr0", 32'(aout), ea(50, 0));
    wait_done(20);
    // Reset while channel 5 is presented.
    set_bus(100, 100, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("b5_ch5", 32'(dout), ed(100, 100, 5));
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(ov), 32'd0);
    check("ar_data", 32'(dout), 32'd0);
    check("ar_addr", 32'(aout), 32'd0);
    check("ar_busy", 32'(bsy), 32'd0);
    check("ar_done", 32'(dn), 32'd0);
    @(negedge clk);
    check("ar_no_done", 32'(dn), 32'd0);
    #2 rst_n = 1'b1;
    set_bus(-1, -1, 63);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("b6_data0", 32'(dout), ed(-1, -1, 0));
    check("b6_addr0", 32'(aout), ea(63, 0));
    wait_done(20);
    // Two-channel, 8-bit instance: extreme signed values pass bit-exact.
    data2 = {8'h7F, 8'h80};
    addr2 = {6'd9, 6'd3};
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    @(negedge clk);
    check("n2_valid0", 32'(ov2), 32'd1);
    check("n2_data0", 32'(dout2), 32'h80);
    check("n2_addr0", 32'(aout2), 32'd3);
    @(negedge clk);
    check("n2_data1", 32'(dout2), 32'h7F);
    check("n2_addr1", 32'(aout2), 32'd9);
    check("n2_nodone", 32'(dn2), 32'd0);
    @(negedge clk);
    check("n2_done", 32'(dn2), 32'd1);
    check("n2_idle", 32'(ov2), 32'd0);
    @(negedge clk);
    check("n2_done_pulse", 32'(dn2), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
